// File: rtl/vec_alu_exec_pkg.sv
// Shared types for the vector ALU execute stage and the upstream decoder.
package vec_alu_exec_pkg;

    localparam int unsigned DEF_LANES = 4;
    localparam int unsigned DEF_W     = 8;

    typedef enum logic [2:0] {
        ALU_NOP  = 3'b000,
        ALU_PASS = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_MUL  = 3'b100,
        ALU_DIV  = 3'b101
    } alu_op_t;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_DIV_RUN = 1'b1
    } exec_state_t;

    // Ops whose result is registered on the accept edge.
    function automatic logic is_single_cycle(input alu_op_t op);
        return (op == ALU_PASS) || (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_MUL);
    endfunction

endpackage

// File: rtl/vec_alu_exec_vdiv_lane.sv
// One lane of the restoring divider: produces one quotient bit per step.
module vdiv_lane #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient_next_c
);

    logic [W-1:0] rem;
    logic [W-1:0] quo;
    logic [W-1:0] dvs;
    logic [W:0]   shifted;
    logic [W:0]   diff;
    logic         ge;
    logic [W-1:0] rem_next;

    // Shift next dividend bit into the remainder; subtract if it fits.
    // A zero divisor always "fits", which yields an all-ones quotient.
    assign shifted         = {rem, quo[W-1]};
    assign diff            = shifted - {1'b0, dvs};
    assign ge              = (shifted >= {1'b0, dvs});
    assign rem_next        = W'(ge ? diff : shifted);
    assign quotient_next_c = {quo[W-2:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (step) begin
            rem <= rem_next;
            quo <= quotient_next_c;
        end
    end

endmodule

// File: rtl/vec_alu_exec.sv
// Vector ALU execute stage: saturating add/sub, alpha multiply, iterative divide,
// with valid/ready handshakes on both sides.
module vec_alu_exec
    import vec_alu_exec_pkg::*;
#(
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned W     = DEF_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_op,
    input  logic [LANES*W-1:0] op1,
    input  logic [LANES*W-1:0] op2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] result,
    output logic               flag_z,
    output logic               flag_n
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    exec_state_t        state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [LANES*W-1:0] result_next;
    logic               out_valid_next;
    logic               flag_z_next, flag_n_next;
    logic               div_load, div_step;
    logic               accept;
    alu_op_t            op;
    logic [LANES*W-1:0] alu_vec;
    logic [LANES*W-1:0] div_q_next;

    assign op       = alu_op_t'(alu_op);
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [W-1:0] a, b, r, mul_hi;
        logic [W:0]   sum;

        assign a      = op1[g*W +: W];
        assign b      = op2[g*W +: W];
        assign sum    = {1'b0, a} + {1'b0, b};
        // High half of the 2W-bit product: fixed-point alpha scaling.
        assign mul_hi = W'(((2*W)'(a) * (2*W)'(b)) >> W);

        always_comb begin
            r = a;
            case (op)
                ALU_ADD: r = sum[W] ? '1 : sum[W-1:0];
                ALU_SUB: r = (a >= b) ? (a - b) : '0;
                ALU_MUL: r = mul_hi;
                default: r = a;
            endcase
        end

        assign alu_vec[g*W +: W] = r;

        vdiv_lane #(.W(W)) u_div (
            .clk             (clk),
            .rst_n           (rst_n),
            .load            (div_load),
            .step            (div_step),
            .dividend        (a),
            .divisor         (b),
            .quotient_next_c (div_q_next[g*W +: W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            result    <= result_next;
            out_valid <= out_valid_next;
            flag_z    <= flag_z_next;
            flag_n    <= flag_n_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        result_next    = result;
        out_valid_next = out_valid;
        flag_z_next    = flag_z;
        flag_n_next    = flag_n;
        div_load       = 1'b0;
        div_step       = 1'b0;

        if (out_valid && out_ready) begin
            out_valid_next = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_single_cycle(op)) begin
                        result_next    = alu_vec;
                        out_valid_next = 1'b1;
                        if (op == ALU_SUB) begin
                            flag_z_next = (op1[W-1:0] == op2[W-1:0]);
                            flag_n_next = (op1[W-1:0] <  op2[W-1:0]);
                        end
                    end else if (op == ALU_DIV) begin
                        div_load   = 1'b1;
                        cnt_next   = '0;
                        state_next = S_DIV_RUN;
                    end
                end
            end
            S_DIV_RUN: begin
                div_step = 1'b1;
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(W - 1)) begin
                    result_next    = div_q_next;
                    out_valid_next = 1'b1;
                    state_next     = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vec_alu_exec.sv
// Directed and randomized checks of vec_alu_exec against a lane-arithmetic reference model.
module tb_vec_alu_exec;

    localparam int unsigned LANES = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned MAXV  = (1 << W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         alu_op;
    logic [LANES*W-1:0] op1, op2;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*W-1:0] result;
    logic               flag_z, flag_n;

    int checks = 0;
    int errors = 0;

    vec_alu_exec #(.LANES(LANES), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_op   = op;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        #1;
        chk("issue_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        alu_op   = 3'd0;
    endtask

    // Reference: each lane computed with plain integer arithmetic.
    function automatic logic [31:0] ref_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int unsigned x, y, z;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            x = a[i*W +: W];
            y = b[i*W +: W];
            case (op)
                3'd1:    z = x;
                3'd2:    z = (x + y > MAXV) ? MAXV : x + y;
                3'd3:    z = (x > y) ? x - y : 0;
                3'd4:    z = (x * y) >> W;
                3'd5:    z = (y == 0) ? MAXV : x / y;
                default: z = 0;
            endcase
            r[i*W +: W] = W'(z);
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_vec();
        logic [31:0] v;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*W +: W] = '0;
                1:       v[i*W +: W] = W'(MAXV);
                default: v[i*W +: W] = W'($urandom);
            endcase
        end
        return v;
    endfunction

    logic [31:0] held;
    logic        m_valid, m_z, m_n, acc;
    logic [31:0] m_result, m_div;
    int          m_busy;
    logic        exp_ready;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_op    = 3'd0;
        op1       = '0;
        op2       = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result",    result,    32'h0);
        chk("rst_flags",     {flag_z, flag_n}, 2'b00);
        chk("rst_in_ready",  in_ready,  1'b1);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a divide: nothing must come out.
        issue(3'd5, 32'h64FF0709, 32'h0701000A);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstdiv_out_valid", out_valid, 1'b0);
        chk("rstdiv_result",    result,    32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rstdiv_in_ready", in_ready, 1'b1);
        for (int k = 0; k < 12; k++) begin
            chk("rstdiv_no_result", out_valid, 1'b0);
            tick();
        end

        // Saturating add.
        issue(3'd2, 32'hC80AFF00, 32'h64050100);
        chk("add_valid",  out_valid, 1'b1);
        chk("add_result", result,    32'hFF0FFF00);

        // SUB flags: 5-9 then 7-7, then ADD must leave flags alone.
        issue(3'd3, 32'h14300005, 32'h0A400009);
        chk("sub1_result", result, 32'h0A000000);
        chk("sub1_flags",  {flag_z, flag_n}, 2'b01);
        issue(3'd3, 32'h00000007, 32'h00000007);
        chk("sub2_result", result, 32'h00000000);
        chk("sub2_flags",  {flag_z, flag_n}, 2'b10);
        issue(3'd2, 32'h01020304, 32'h01010101);
        chk("add2_result", result, 32'h02030405);
        chk("add2_flags",  {flag_z, flag_n}, 2'b10);

        // Alpha multiply.
        issue(3'd4, 32'hFF804000, 32'hFF80FF4D);
        chk("mul_result", result, 32'hFE403F00);

        // Divide: W+1 cycle latency, stalled input meanwhile.
        issue(3'd5, 32'h64FF0709, 32'h0701000A);
        for (int k = 1; k <= 8; k++) begin
            chk("div_busy", {in_ready, out_valid}, 2'b00);
            tick();
        end
        chk("div_valid",  out_valid, 1'b1);
        chk("div_result", result,    32'h0EFF_FF00);

        // Back-pressure with a PASS waiting behind a held ADD.
        tick();
        out_ready = 1'b0;
        issue(3'd2, 32'h10203040, 32'h01020304);
        held = 32'h11223344;
        chk("bp_add_result", result, held);
        alu_op   = 3'd1;
        op1      = 32'hA5A55A5A;
        op2      = 32'h0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_hold_valid",  out_valid, 1'b1);
            chk("bp_hold_result", result,    held);
            chk("bp_hold_ready",  in_ready,  1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("bp_pass_valid",  out_valid, 1'b1);
        chk("bp_pass_result", result,    32'hA5A55A5A);
        tick();
        chk("bp_drain", out_valid, 1'b0);

        // Randomized traffic against the reference model, starting from reset.
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        m_valid  = 1'b0;
        m_z      = 1'b0;
        m_n      = 1'b0;
        m_busy   = 0;
        m_result = '0;
        m_div    = '0;
        tick();
        for (int it = 0; it < 400; it++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            alu_op    = 3'($urandom_range(0, 7));
            op1       = rand_vec();
            op2       = rand_vec();
            #1;
            exp_ready = (m_busy == 0) && (!m_valid || out_ready);
            chk("rnd_in_ready",  in_ready,  exp_ready);
            chk("rnd_out_valid", out_valid, m_valid);
            chk("rnd_flags",     {flag_z, flag_n}, {m_z, m_n});
            if (m_valid) chk("rnd_result", result, m_result);

            acc = in_valid && exp_ready;
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid  = 1'b1;
                    m_result = m_div;
                end
            end else if (acc) begin
                if (alu_op >= 3'd1 && alu_op <= 3'd4) begin
                    m_valid  = 1'b1;
                    m_result = ref_vec(alu_op, op1, op2);
                    if (alu_op == 3'd3) begin
                        m_z = (op1[W-1:0] == op2[W-1:0]);
                        m_n = (op1[W-1:0] <  op2[W-1:0]);
                    end
                end else if (alu_op == 3'd5) begin
                    m_busy = W;
                    m_div  = ref_vec(alu_op, op1, op2);
                end
            end
            tick();
        end
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
